word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 Parameter DATA_W, default 8: width of one input beat, which matches the FIFO data_out width.
REQ-002 Parameter LANES, default 4: number of beats packed per output word; LANES SHALL be at least 2.
REQ-003 Parameter TIMEOUT, default 16: idle cycles before a partial word is flushed; 0 disables the timeout.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port in_data, input, DATA_W: beat from the upstream FIFO data_out.
REQ-007 Port in_vld, input, 1: in_data valid; driven by FIFO data_out_vld.
REQ-008 Port in_rdy, output, 1: block accepts a beat; drives FIFO data_out_rdy.
REQ-009 Port flush, input, 1: single-cycle request to emit the current partial word.
REQ-010 Port pkd_data, output, DATA_W*LANES: packed word, with lane 0 in the least-significant bits.
REQ-011 Port pkd_keep, output, LANES: per-lane valid mask.
REQ-012 Port pkd_vld, output, 1: packed word valid.
REQ-013 Port pkd_rdy, input, 1: downstream accepts the packed word.
REQ-014 Port word_cnt, output, 16: count of words emitted, wrapping at 2^16.

Function
REQ-015 A beat SHALL transfer when in_vld and in_rdy are both high at a rising edge; the transfer shall be a pure valid/ready handshake.
REQ-016 Accepted beats SHALL fill the accumulator in order: lane 0, then lane 1, and so on up to lane LANES-1.
REQ-017 States: EMPTY (count 0), FILL (0 < count < LANES), HELD (count == LANES, waiting for the output register).
REQ-018 in_rdy SHALL be high in EMPTY and FILL, and low in HELD; in_rdy SHALL be registered, with no combinational path from pkd_rdy.
REQ-019 out_free SHALL be defined as (pkd_vld == 0) or (pkd_rdy == 1).
REQ-020 When the completing beat (count LANES-1) is accepted and out_free is high, the word SHALL load into the output register at the same edge, and the state SHALL go to EMPTY.
REQ-021 When the completing beat is accepted and out_free is low, the state SHALL go to HELD; the word SHALL load at the first edge at which out_free is high, and the state SHALL then go to EMPTY.
REQ-022 Sustained throughput SHALL be one beat per cycle while pkd_rdy is held high.
REQ-023 The idle counter SHALL clear on any accepted beat and increment each cycle in FILL otherwise, saturating at TIMEOUT.
REQ-024 A partial flush SHALL trigger in FILL when the idle count equals TIMEOUT (with TIMEOUT nonzero), or when flush was seen since the last load.
REQ-025 A triggered flush SHALL load the partial word when out_free is high; otherwise it SHALL stay pending, and the block SHALL keep accepting beats into the same word.
REQ-026 The pkd_keep bits SHALL be set for the filled lanes only; unfilled lanes of pkd_data SHALL be driven to zero.
REQ-027 If a flush trigger coincides with acceptance of the completing beat, a single full word SHALL be emitted, with no extra empty word.
REQ-028 A flush request in EMPTY SHALL be ignored and SHALL emit no word.
REQ-029 pkd_data and pkd_keep SHALL hold stable while pkd_vld is high and pkd_rdy is low.
REQ-030 pkd_vld SHALL drop after the accepting edge unless a new load occurs at that same edge.
REQ-031 word_cnt SHALL increment once per load into the output register.

Reset
REQ-032 While rst is low: pkd_vld, in_rdy, pkd_data, pkd_keep, word_cnt, the count, the idle counter and the pending flush SHALL all be 0, and the state SHALL be EMPTY.
REQ-033 in_rdy SHALL rise on the first clock edge after rst deasserts.
REQ-034 Reset asserted mid-word SHALL discard the partial word and any pending output, with no flush on release.

Structure
REQ-035 Package word_packer_pkg SHALL hold the state enum and the default values of DATA_W, LANES and TIMEOUT.
REQ-036 The idle timeout SHALL be implemented in a sub-module, word_packer_timer (inputs: clear, enable; output: expired).

Verification (DATA_W=8, LANES=4, TIMEOUT=16)
REQ-037 Beats 0x11, 0x22, 0x33, 0x44 sent back-to-back with pkd_rdy=1 -> pkd_data=0x44332211 and pkd_keep=0xF one cycle after the 4th beat, and word_cnt=1.
REQ-038 Beats 0x01 to 0x08 streamed continuously with pkd_rdy=1 -> in_rdy never low; words 0x04030201 then 0x08070605.
REQ-039 Beats 0xA1, 0xA2, then idle -> after 16 idle cycles, pkd_data=0x0000A2A1 and pkd_keep=0x3.
REQ-040 pkd_rdy=0 while 8 beats are sent -> in_rdy low after the 8th beat; when pkd_rdy rises, in_rdy returns within 1 cycle and the two words emerge in order.
REQ-041 Beat 0x5A, then flush pulse -> word 0x0000005A with pkd_keep=0x1; a flush pulse in EMPTY -> no word, word_cnt unchanged.
REQ-042 rst pulsed low after 3 beats -> outputs zero immediately; a subsequent 4 beats produce exactly one full word.

Source files
------------

// File: rtl/word_packer_pkg.sv
// word_packer_pkg
//   Shared definitions for the beat-to-word packer: default parameter
//   values and the accumulator state encoding.
//     ST_EMPTY : no beats collected
//     ST_FILL  : some, but not all, lanes collected
//     ST_HELD  : all lanes collected, waiting for the output register
package word_packer_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

endpackage

// File: rtl/word_packer_timer.sv
// word_packer_timer
//   Idle counter for the packer. Counts cycles while enabled, saturating
//   at TIMEOUT; clear has priority over enable. TIMEOUT = 0 disables it.
//   Ports:
//     clk     : clock, rising edge
//     rst     : asynchronous, active-low reset
//     clear   : zero the idle count this cycle
//     enable  : count this cycle (when not cleared)
//     expired : idle count has reached TIMEOUT (never when TIMEOUT = 0)
module word_packer_timer
  import word_packer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // At least one bit so the counter stays legal when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (clear) begin
      r_idle <= '0;
    end else if (enable && (r_idle != C_LIMIT)) begin
      r_idle <= r_idle + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (r_idle == C_LIMIT);

endmodule

// File: rtl/word_packer.sv
// word_packer
//   Packs LANES consecutive DATA_W beats from a valid/ready source into one
//   wide word (lane 0 in the LSBs). A partial word is emitted on an explicit
//   flush request or after TIMEOUT idle cycles, with pkd_keep marking the
//   filled lanes and unfilled lanes forced to zero.
//   Ports:
//     clk      : clock, rising edge
//     rst      : asynchronous, active-low reset
//     in_data  : input beat
//     in_vld   : input beat valid
//     in_rdy   : packer can accept a beat (registered)
//     flush    : single-cycle request to emit the current partial word
//     pkd_data : packed output word
//     pkd_keep : per-lane valid mask of pkd_data
//     pkd_vld  : packed word valid
//     pkd_rdy  : downstream accepts the packed word
//     word_cnt : number of words loaded into the output register (wraps)
module word_packer
  import word_packer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic                      flush,
  output logic [DATA_W*LANES-1:0]   pkd_data,
  output logic [LANES-1:0]          pkd_keep,
  output logic                      pkd_vld,
  input  logic                      pkd_rdy,
  output logic [15:0]               word_cnt
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] C_LANES = CNT_W'(LANES);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_acc;
  logic [CNT_W-1:0]          w_cnt_next;
  logic                      r_flush_pend;
  logic                      w_flush_pend_next;
  logic                      r_in_rdy;
  logic [DATA_W*LANES-1:0]   r_pkd_data;
  logic [LANES-1:0]          r_pkd_keep;
  logic                      r_pkd_vld;
  logic [15:0]               r_word_cnt;

  logic                      w_accept;
  logic                      w_out_free;
  logic                      w_full;
  logic                      w_trig;
  logic                      w_load;
  logic                      w_expired;
  logic                      w_timer_clear;
  logic                      w_timer_en;
  logic [DATA_W*LANES-1:0]   w_word;
  logic [LANES-1:0]          w_keep;

  assign w_accept   = in_vld & r_in_rdy;
  assign w_out_free = ~r_pkd_vld | pkd_rdy;

  // Lane count including a beat accepted at this edge.
  assign w_cnt_acc  = r_cnt + {{(CNT_W-1){1'b0}}, w_accept};
  assign w_full     = (w_cnt_acc == C_LANES);

  // A flush request is honoured only while a partial word exists; the
  // request latched earlier and the one arriving now are treated alike.
  assign w_trig = (r_state == ST_FILL) & (flush | r_flush_pend | w_expired);

  // The loaded word always contains every beat accepted up to and
  // including this edge, so a flush that coincides with the completing
  // beat yields one full word rather than a partial one plus an empty one.
  assign w_load     = w_out_free & (w_full | w_trig);
  assign w_cnt_next = w_load ? '0 : w_cnt_acc;

  assign w_flush_pend_next = w_load ? 1'b0
                           : (r_flush_pend | (flush & (r_state != ST_EMPTY)));

  always_comb begin
    w_state_next = ST_FILL;
    if (w_cnt_next == '0) begin
      w_state_next = ST_EMPTY;
    end else if (w_cnt_next == C_LANES) begin
      w_state_next = ST_HELD;
    end
  end

  // Idle cycles only count while a partial word is waiting for more beats.
  assign w_timer_clear = w_accept | w_load | (r_state != ST_FILL);
  assign w_timer_en    = (r_state == ST_FILL);

  word_packer_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  // Per-lane accumulator. A beat accepted at the load edge bypasses its
  // lane register straight into the output word.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] r_lane;
    logic              w_wr;

    assign w_wr = w_accept & (r_cnt == CNT_W'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_lane <= '0;
      end else if (w_wr) begin
        r_lane <= in_data;
      end
    end

    assign w_keep[gi] = (CNT_W'(gi) < w_cnt_acc);
    assign w_word[gi*DATA_W +: DATA_W] = w_keep[gi] ? (w_wr ? in_data : r_lane)
                                                    : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_in_rdy     <= 1'b0;
      r_pkd_data   <= '0;
      r_pkd_keep   <= '0;
      r_pkd_vld    <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_flush_pend <= w_flush_pend_next;
      // Registered from the next state, so no path from pkd_rdy to in_rdy.
      r_in_rdy     <= (w_state_next != ST_HELD);
      if (w_load) begin
        r_pkd_data <= w_word;
        r_pkd_keep <= w_keep;
        r_pkd_vld  <= 1'b1;
        r_word_cnt <= r_word_cnt + 16'd1;
      end else if (pkd_rdy) begin
        r_pkd_vld  <= 1'b0;
      end
    end
  end

  assign in_rdy   = r_in_rdy;
  assign pkd_data = r_pkd_data;
  assign pkd_keep = r_pkd_keep;
  assign pkd_vld  = r_pkd_vld;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   in_data = '0;
  logic            in_vld = 1'b0;
  logic            in_rdy;
  logic            flush = 1'b0;
  logic [DW*L-1:0] pkd_data;
  logic [L-1:0]    pkd_keep;
  logic            pkd_vld;
  logic            pkd_rdy = 1'b0;
  logic [15:0]     word_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  word_packer #(.DATA_W(DW), .LANES(L), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .flush    (flush),
    .pkd_data (pkd_data),
    .pkd_keep (pkd_keep),
    .pkd_vld  (pkd_vld),
    .pkd_rdy  (pkd_rdy),
    .word_cnt (word_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Current partial word as a queue of beats; output register as plain values.
  logic [DW-1:0]   m_q[$];
  int              m_idle;
  bit              m_pend;
  bit              m_rdy;
  bit              m_vld;
  logic [DW*L-1:0] m_data;
  logic [L-1:0]    m_keep;
  logic [15:0]     m_wcnt;
  logic [DW-1:0]   sb[$];          // accepted beats not yet seen leaving the DUT
  logic [DW*L-1:0] obs_words[$];   // words seen leaving the DUT

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_idle = 0;
    m_pend = 1'b0;
    m_rdy  = 1'b0;
    m_vld  = 1'b0;
    m_data = '0;
    m_keep = '0;
    m_wcnt = '0;
  endtask

  // Advance the model across one rising edge using the inputs as they will be sampled.
  task automatic model_step();
    int n0;
    bit acc, fill0, free, trig, load;
    n0    = m_q.size();
    acc   = in_vld && m_rdy;
    fill0 = (n0 > 0) && (n0 < L);
    free  = !m_vld || pkd_rdy;
    if (acc) begin
      m_q.push_back(in_data);
      sb.push_back(in_data);
    end
    trig = fill0 && (flush || m_pend || (TO != 0 && m_idle == TO));
    load = free && ((m_q.size() == L) || trig);
    if (load) m_pend = 1'b0;
    else if (flush && n0 > 0) m_pend = 1'b1;
    if (acc || load || !fill0) m_idle = 0;
    else if (m_idle < TO) m_idle++;
    if (load) begin
      m_data = '0;
      m_keep = '0;
      for (int i = 0; i < m_q.size(); i++) begin
        m_data[i*DW +: DW] = m_q[i];
        m_keep[i] = 1'b1;
      end
      m_vld = 1'b1;
      m_wcnt = m_wcnt + 16'd1;
      m_q.delete();
    end else if (pkd_rdy) begin
      m_vld = 1'b0;
    end
    m_rdy = (m_q.size() != L);
  endtask

  // Compare process: runs mid-low-phase, after inputs settle, before the next edge.
  initial begin
    logic [DW-1:0] e;
    model_reset();
    wait (chk_on);
    forever begin
      @(negedge clk);
      #3;
      if (!rst) model_reset();
      chk("cyc_in_rdy",   in_rdy,   m_rdy);
      chk("cyc_pkd_vld",  pkd_vld,  m_vld);
      chk("cyc_pkd_data", pkd_data, m_data);
      chk("cyc_pkd_keep", pkd_keep, m_keep);
      chk("cyc_word_cnt", word_cnt, m_wcnt);
      if (rst && pkd_vld && pkd_rdy) begin
        obs_words.push_back(pkd_data);
        chk("sb_keep_shape", (pkd_keep == 4'h1 || pkd_keep == 4'h3 ||
                              pkd_keep == 4'h7 || pkd_keep == 4'hF), 1'b1);
        for (int i = 0; i < L; i++) begin
          if (pkd_keep[i]) begin
            chk("sb_avail", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("sb_lane", pkd_data[i*DW +: DW], e);
            end
          end
        end
      end
      if (rst) model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0; flush = 1'b0;
    #1;
    chk("rst_pkd_vld",  pkd_vld,  1'b0);
    chk("rst_in_rdy",   in_rdy,   1'b0);
    chk("rst_pkd_data", pkd_data, 32'h0);
    chk("rst_pkd_keep", pkd_keep, 4'h0);
    chk("rst_word_cnt", word_cnt, 16'h0);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_in_rdy_low", in_rdy, 1'b0);
    @(negedge clk);
    #1 chk("rel_in_rdy_high", in_rdy, 1'b1);
    obs_words.delete();
  endtask

  task automatic send(input logic [DW-1:0] b);
    @(negedge clk);
    in_vld = 1'b1;
    in_data = b;
  endtask

  initial begin
    int w;
    int mode_v, mode_r;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int pv, pr;

    // Four back-to-back beats form one full word.
    reset_dut();
    pkd_rdy = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk); in_vld = 1'b0;
    #1;
    chk("d1_vld",  pkd_vld,  1'b1);
    chk("d1_data", pkd_data, 32'h44332211);
    chk("d1_keep", pkd_keep, 4'hF);
    chk("d1_wcnt", word_cnt, 16'd1);
    $display("[TB] directed full word: data=0x%08h keep=0x%0h", pkd_data, pkd_keep);

    // Continuous stream keeps in_rdy high.
    reset_dut();
    pkd_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      #1 chk("d2_in_rdy", in_rdy, 1'b1);
    end
    @(negedge clk); in_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("d2_nwords", obs_words.size(), 2);
    if (obs_words.size() >= 2) begin
      chk("d2_word0", obs_words[0], 32'h04030201);
      chk("d2_word1", obs_words[1], 32'h08070605);
    end
    $display("[TB] directed stream: %0d words", obs_words.size());

    // Idle timeout flushes a partial word.
    reset_dut();
    pkd_rdy = 1'b1;
    send(8'hA1); send(8'hA2);
    @(negedge clk); in_vld = 1'b0;
    w = 0;
    #1;
    while (!pkd_vld && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("d3_fired",   pkd_vld, 1'b1);
    chk("d3_latency", (w >= 16 && w <= 18), 1'b1);
    chk("d3_data",    pkd_data, 32'h0000A2A1);
    chk("d3_keep",    pkd_keep, 4'h3);
    $display("[TB] directed timeout: waited %0d cycles, data=0x%08h", w, pkd_data);

    // Back-pressure: held word stalls input, releases in order.
    reset_dut();
    pkd_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(8'h80 + i));
    @(negedge clk); in_vld = 1'b0;
    #1;
    chk("d4_in_rdy_low", in_rdy,   1'b0);
    chk("d4_held_data",  pkd_data, 32'h84838281);
    repeat (2) @(negedge clk);
    #1 chk("d4_still_low", in_rdy, 1'b0);
    @(negedge clk); pkd_rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("d4_in_rdy_back", in_rdy,   1'b1);
    chk("d4_word2_data",  pkd_data, 32'h88878685);
    @(negedge clk);
    #1;
    chk("d4_nwords", obs_words.size(), 2);
    if (obs_words.size() >= 2) begin
      chk("d4_word0", obs_words[0], 32'h84838281);
      chk("d4_word1", obs_words[1], 32'h88878685);
    end
    $display("[TB] directed backpressure: %0d words", obs_words.size());

    // Explicit flush of a single beat, then a flush in EMPTY.
    reset_dut();
    pkd_rdy = 1'b1;
    send(8'h5A);
    @(negedge clk); in_vld = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    chk("d5_vld",  pkd_vld,  1'b1);
    chk("d5_data", pkd_data, 32'h0000005A);
    chk("d5_keep", pkd_keep, 4'h1);
    chk("d5_wcnt", word_cnt, 16'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("d5_empty_vld",  pkd_vld,  1'b0);
    chk("d5_empty_wcnt", word_cnt, 16'd1);
    $display("[TB] directed flush: word_cnt=%0d", word_cnt);

    // Reset mid-word discards the partial word.
    reset_dut();
    pkd_rdy = 1'b1;
    send(8'hC1); send(8'hC2); send(8'hC3);
    @(negedge clk); in_vld = 1'b0; rst = 1'b0;
    #1;
    chk("d6_vld",    pkd_vld,  1'b0);
    chk("d6_data",   pkd_data, 32'h0);
    chk("d6_keep",   pkd_keep, 4'h0);
    chk("d6_in_rdy", in_rdy,   1'b0);
    chk("d6_wcnt",   word_cnt, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
    @(negedge clk); in_vld = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("d6_nwords", obs_words.size(), 1);
    if (obs_words.size() >= 1) chk("d6_word0", obs_words[0], 32'hD4D3D2D1);
    chk("d6_wcnt_after", word_cnt, 16'd1);
    $display("[TB] directed reset mid-word: %0d words after release", obs_words.size());

    // Randomized traffic, checked every cycle by the model.
    reset_dut();
    pv = 50; pr = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc % 250 == 0) begin
        pv = $urandom_range(3, 100);
        pr = $urandom_range(10, 100);
        $display("[TB] random phase at cycle %0d: vld%%=%0d rdy%%=%0d", cyc, pv, pr);
      end
      in_vld  = ($urandom_range(0, 99) < pv);
      in_data = 8'($urandom);
      pkd_rdy = ($urandom_range(0, 99) < pr);
      flush   = ($urandom_range(0, 39) == 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rst = 1'b0;
    end
    @(negedge clk);
    in_vld = 1'b0; flush = 1'b0; rst = 1'b1; pkd_rdy = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
